tt_uio_arbiter: RTL and testbench
=================================

TT_UIO_ARBITER -- requirements
Module: tt_uio_arbiter

Interface
REQ-001 Parameter LW, default 4: width of each burst-length field; a burst is len+1 beats (1..2^LW).
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 ena  input  1  design-enable; low freezes all state.
REQ-005 req  input  2  per-requester burst request, bit i = requester i.
REQ-006 dir  input  2  per-requester direction: 1 = drive uio (write), 0 = sample uio (read).
REQ-007 len0, len1  input  LW each  per-requester beat count minus one.
REQ-008 wdata0, wdata1  input  8 each  per-requester write byte for the current beat.
REQ-009 uio_in  input  8  bidirectional-pin input path.
REQ-010 uio_out  output  8  bidirectional-pin output path.
REQ-011 uio_oe  output  8  pin output enables, active high.
REQ-012 gnt  output  2  one-hot grant, held for the whole burst including turnaround.
REQ-013 beat  output  2  one-hot strobe, high in each cycle a beat transfers for that requester.
REQ-014 rdata  output  8  registered sample of uio_in from the last read beat.
REQ-015 rvalid  output  1  one-cycle pulse, the cycle after a read beat, qualifying rdata.
REQ-016 done  output  2  one-cycle pulse, the cycle after the last beat of the requester's burst.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 States SHALL be IDLE, TURN and BURST; all transitions SHALL occur only on rising clk with ena high.
REQ-019 In IDLE with any req bit high, the block SHALL register the grant, the granted dir and len, and leave IDLE on the next edge.
REQ-020 Arbitration SHALL be round-robin: a lone requester wins; on simultaneous requests the pointer holder wins; the pointer moves to the other requester after each grant; the pointer resets to requester 0.
REQ-021 req, dir and len SHALL be sampled only at grant; changes or req deassertion mid-burst SHALL NOT affect the burst.
REQ-022 The next state SHALL be TURN when the granted dir differs from register lastdir (reset 0), otherwise BURST; TURN SHALL last exactly one cycle and then go to BURST.
REQ-023 BURST SHALL transfer one beat per ena-high cycle, decrementing a beat counter loaded with len, and SHALL return to IDLE after the beat at which the counter is 0.
REQ-024 lastdir SHALL update to the granted dir on entry to BURST.
REQ-025 In BURST with dir=1, uio_oe SHALL be 8'hFF and uio_out SHALL equal the granted wdata combinationally; in all other cycles uio_oe SHALL be 8'h00 and uio_out 8'h00.
REQ-026 On a read beat, rdata SHALL load uio_in and rvalid SHALL pulse on the following cycle.
REQ-027 A new grant MAY be issued in the same cycle that done pulses (back-to-back bursts, one IDLE cycle between them).
REQ-028 With ena low, state, counter, pointer and lastdir SHALL hold; beat, rvalid and done SHALL be 0; uio_oe SHALL retain its current value.

Reset
REQ-029 On rst: state IDLE; gnt, beat, done and rvalid at 0; busy at 0; rdata 8'h00; uio_oe 8'h00; uio_out 8'h00; pointer 0; lastdir 0.
REQ-030 rst asserted mid-burst SHALL abort the burst without a done pulse; the pins SHALL be released on the same edge.

Configuration
REQ-031 With macro UIO_ARB_TURNAROUND_EN defined, the TURN state SHALL be inserted per REQ-022.
REQ-032 Without UIO_ARB_TURNAROUND_EN, the block SHALL always go from IDLE directly to BURST, and the TURN state SHALL be absent.

Verification
REQ-033 After rst, req=2'b01, dir0=1, len0=2, wdata0=8'hA5 -> TURN for 1 cycle, then 3 beats with uio_oe=8'hFF and uio_out=8'hA5, then done[0] pulse.
REQ-034 req=2'b11 held after reset, both dir=0, len=0 -> grants in order 0,1,0,1; each burst is 1 beat; no TURN.
REQ-035 Read burst, len1=1, uio_in=8'h3C then 8'hC3 -> rvalid pulses twice, rdata 8'h3C then 8'hC3, uio_oe stays 8'h00.
REQ-036 Write burst len=3, ena low during the 2nd beat for 2 cycles -> beats pause, uio_oe held at 8'hFF, exactly 4 beats total.
REQ-037 rst during the 2nd beat of a write burst -> next cycle uio_oe=8'h00, busy=0, no done pulse.
REQ-038 Build without UIO_ARB_TURNAROUND_EN, read burst then write burst -> write beats start the cycle after grant, with no TURN cycle.

Source files
------------

// File: rtl/tt_uio_arbiter.sv
// Two-requester round-robin burst arbiter that shares the 8-bit uio bidirectional pins.
// Optional macro UIO_ARB_TURNAROUND_EN inserts a one-cycle TURN state on a bus direction change.
module tt_uio_arbiter #(
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic [1:0]    req,
   input  logic [1:0]    dir,
   input  logic [LW-1:0] len0,
   input  logic [LW-1:0] len1,
   input  logic [7:0]    wdata0,
   input  logic [7:0]    wdata1,
   input  logic [7:0]    uio_in,
   output logic [7:0]    uio_out,
   output logic [7:0]    uio_oe,
   output logic [1:0]    gnt,
   output logic [1:0]    beat,
   output logic [7:0]    rdata,
   output logic          rvalid,
   output logic [1:0]    done,
   output logic          busy
);

`ifdef UIO_ARB_TURNAROUND_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_TURN = 2'd1, ST_BURST = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BURST = 2'd2} state_t;
`endif

   state_t        r_state;
   state_t        w_next;
   logic [1:0]    r_gnt;
   logic          r_dir;
   logic [LW-1:0] r_cnt;
   logic          r_ptr;
   logic [7:0]    r_rdata;
   logic          r_rvalid;
   logic [1:0]    r_done;
   logic          w_win;
   logic          w_in_burst;
   logic          w_drive;
`ifdef UIO_ARB_TURNAROUND_EN
   logic          r_lastdir;
`endif

   // Round-robin winner: a lone requester wins outright, a tie goes to the pointer holder.
   always_comb begin
      w_win = r_ptr;
      case (req)
         2'b01:   w_win = 1'b0;
         2'b10:   w_win = 1'b1;
         2'b11:   w_win = r_ptr;
         default: w_win = r_ptr;
      endcase
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req != 2'b00) begin
`ifdef UIO_ARB_TURNAROUND_EN
               if (dir[w_win] != r_lastdir) begin
                  w_next = ST_TURN;
               end else begin
                  w_next = ST_BURST;
               end
`else
               w_next = ST_BURST;
`endif
            end else begin
               w_next = ST_IDLE;
            end
         end
`ifdef UIO_ARB_TURNAROUND_EN
         ST_TURN: w_next = ST_BURST;
`endif
         ST_BURST: begin
            if (r_cnt == {LW{1'b0}}) begin
               w_next = ST_IDLE;
            end else begin
               w_next = ST_BURST;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register; ena low freezes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else if (ena) begin
         r_state <= w_next;
      end
   end

   // Grant capture, beat counter, read sampling and completion pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt    <= 2'b00;
         r_dir    <= 1'b0;
         r_cnt    <= {LW{1'b0}};
         r_ptr    <= 1'b0;
         r_rdata  <= 8'h00;
         r_rvalid <= 1'b0;
         r_done   <= 2'b00;
      end else if (ena) begin
         r_rvalid <= 1'b0;
         r_done   <= 2'b00;
         case (r_state)
            ST_IDLE: begin
               if (req != 2'b00) begin
                  r_gnt <= w_win ? 2'b10 : 2'b01;
                  r_dir <= dir[w_win];
                  r_cnt <= w_win ? len1 : len0;
                  r_ptr <= ~w_win;
               end
            end
            ST_BURST: begin
               if (!r_dir) begin
                  r_rdata  <= uio_in;
                  r_rvalid <= 1'b1;
               end
               if (r_cnt == {LW{1'b0}}) begin
                  r_done <= r_gnt;
                  r_gnt  <= 2'b00;
               end else begin
                  r_cnt <= r_cnt - LW'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef UIO_ARB_TURNAROUND_EN
   // Leaving TURN is the only entry to BURST that can change the bus direction.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lastdir <= 1'b0;
      end else if (ena && (r_state == ST_TURN)) begin
         r_lastdir <= r_dir;
      end
   end
`endif

   assign w_in_burst = (r_state == ST_BURST);
   assign w_drive    = w_in_burst && r_dir;
   assign gnt        = r_gnt;
   assign busy       = (r_state != ST_IDLE);
   assign beat       = (w_in_burst && ena) ? r_gnt : 2'b00;
   assign uio_oe     = w_drive ? 8'hFF : 8'h00;
   assign uio_out    = w_drive ? (r_gnt[1] ? wdata1 : wdata0) : 8'h00;
   assign rdata      = r_rdata;
   assign rvalid     = r_rvalid & ena;
   assign done       = r_done & {2{ena}};

endmodule

// File: tb/tb_tt_uio_arbiter.sv
// Self-checking bench for tt_uio_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tt_uio_arbiter;
`ifdef UIO_ARB_TURNAROUND_EN
   localparam bit TURN_EN = 1'b1;
`else
   localparam bit TURN_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [1:0] req = 2'b00;
   logic [1:0] dir = 2'b00;
   logic [3:0] len0 = 4'd0;
   logic [3:0] len1 = 4'd0;
   logic [7:0] wdata0 = 8'h00;
   logic [7:0] wdata1 = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uio_out, uio_oe, rdata;
   logic [1:0] gnt, beat, done;
   logic       rvalid, busy;

   tt_uio_arbiter #(.LW(4)) dut (
      .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir),
      .len0(len0), .len1(len1), .wdata0(wdata0), .wdata1(wdata1),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .gnt(gnt),
      .beat(beat), .rdata(rdata), .rvalid(rvalid), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a granted burst is "turn cycles still owed" plus "beats still owed".
   bit       m_busy = 1'b0;
   bit       m_turn = 1'b0;
   int       m_left = 0;
   bit       m_own = 1'b0;
   bit       m_dir = 1'b0;
   bit       m_ptr = 1'b0;
   bit       m_last = 1'b0;
   bit [1:0] m_done = 2'b00;
   bit       m_rv = 1'b0;
   bit [7:0] m_rdata = 8'h00;
   bit       m_win;

   always_comb m_win = (req == 2'b01) ? 1'b0 : (req == 2'b10) ? 1'b1 : m_ptr;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0; m_turn <= 1'b0; m_left <= 0; m_ptr <= 1'b0; m_last <= 1'b0;
         m_done <= 2'b00; m_rv <= 1'b0; m_rdata <= 8'h00; m_own <= 1'b0; m_dir <= 1'b0;
      end else if (ena) begin
         m_done <= 2'b00;
         m_rv   <= 1'b0;
         if (!m_busy) begin
            if (req != 2'b00) begin
               m_busy <= 1'b1;
               m_own  <= m_win;
               m_ptr  <= !m_win;
               m_dir  <= dir[m_win];
               m_left <= (m_win ? int'(len1) : int'(len0)) + 1;
               m_turn <= TURN_EN && (dir[m_win] != m_last);
               if (!(TURN_EN && (dir[m_win] != m_last))) m_last <= dir[m_win];
            end
         end else if (m_turn) begin
            m_turn <= 1'b0;
            m_last <= m_dir;
         end else begin
            if (!m_dir) begin
               m_rdata <= uio_in;
               m_rv    <= 1'b1;
            end
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= m_own ? 2'b10 : 2'b01;
            end
            m_left <= m_left - 1;
         end
      end
   end

   logic       e_inb;
   logic [1:0] e_gnt;
   always_comb begin
      e_inb = m_busy && !m_turn;
      e_gnt = m_busy ? (m_own ? 2'b10 : 2'b01) : 2'b00;
   end

   // Scenario monitors fed from DUT outputs, checked against literals.
   int       n_a5 = 0, n_oe = 0, n_turn = 0, n_beat0 = 0, n_done0 = 0, n_done1 = 0;
   int       gq[$];
   bit [7:0] rq[$];
   logic [1:0] prev_gnt = 2'b00;

   task automatic clear_mon();
      n_a5 = 0; n_oe = 0; n_turn = 0; n_beat0 = 0; n_done0 = 0; n_done1 = 0;
      gq.delete(); rq.delete();
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",    32'(busy),    32'(m_busy));
         check("gnt",     32'(gnt),     32'(e_gnt));
         check("beat",    32'(beat),    32'((e_inb && ena) ? e_gnt : 2'b00));
         check("uio_oe",  32'(uio_oe),  32'((e_inb && m_dir) ? 8'hFF : 8'h00));
         check("uio_out", 32'(uio_out), 32'((e_inb && m_dir) ? (m_own ? wdata1 : wdata0) : 8'h00));
         check("rdata",   32'(rdata),   32'(m_rdata));
         check("rvalid",  32'(rvalid),  32'(m_rv && ena));
         check("done",    32'(done),    32'(ena ? m_done : 2'b00));
         if (uio_oe == 8'hFF && uio_out == 8'hA5) n_a5++;
         if (uio_oe != 8'h00) n_oe++;
         if (busy && ena && beat == 2'b00) n_turn++;
         if (beat[0]) n_beat0++;
         if (done[0]) n_done0++;
         if (done[1]) n_done1++;
         if (rvalid) rq.push_back(rdata);
         if (prev_gnt == 2'b00 && gnt != 2'b00) gq.push_back(gnt[1] ? 1 : 0);
         prev_gnt = gnt;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 2'b00;
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      step(1);
      chk_en = 1'b1;
      step(1);
      rst = 1'b0;
      check("rst_uio_oe", 32'(uio_oe), 32'h00);
      check("rst_rdata",  32'(rdata),  32'h00);

      // Write burst of 3 beats from requester 0
      clear_mon();
      req = 2'b01; dir = 2'b01; len0 = 4'd2; wdata0 = 8'hA5;
      step(1);
      req = 2'b00;
      step(7);
      check("wr3_a5_beats", 32'(n_a5),    32'd3);
      check("wr3_done0",    32'(n_done0), 32'd1);
      check("wr3_turns",    32'(n_turn),  32'(TURN_EN ? 1 : 0));

      // Both requesting single-beat reads: alternate 0,1,0,1
      do_reset();
      clear_mon();
      req = 2'b11; dir = 2'b00; len0 = 4'd0; len1 = 4'd0;
      step(7);
      req = 2'b00;
      step(4);
      check("rr_count", 32'(gq.size()), 32'd4);
      for (int i = 0; i < 4 && i < gq.size(); i++) check("rr_order", 32'(gq[i]), 32'(i % 2));
      check("rr_turns", 32'(n_turn), 32'd0);

      // Two-beat read from requester 1
      clear_mon();
      req = 2'b10; dir = 2'b00; len1 = 4'd1; uio_in = 8'h3C;
      step(1);
      req = 2'b00;
      step(1);
      uio_in = 8'hC3;
      step(4);
      check("rd_count", 32'(rq.size()), 32'd2);
      if (rq.size() == 2) begin
         check("rd_first",  32'(rq[0]), 32'h3C);
         check("rd_second", 32'(rq[1]), 32'hC3);
      end
      check("rd_oe_quiet", 32'(n_oe), 32'd0);

      // Four-beat write with ena low for 2 cycles during the 2nd beat
      clear_mon();
      req = 2'b01; dir = 2'b01; len0 = 4'd3; wdata0 = 8'h5A;
      step(1);
      req = 2'b00;
      if (TURN_EN) step(1);
      step(1);
      ena = 1'b0;
      #4;
      check("pause_oe_held", 32'(uio_oe), 32'hFF);
      step(2);
      ena = 1'b1;
      wdata0 = 8'h66;
      step(6);
      check("pause_beats", 32'(n_beat0), 32'd4);

      // Reset in the middle of a write burst
      clear_mon();
      req = 2'b10; dir = 2'b10; len1 = 4'd3; wdata1 = 8'h77;
      step(1);
      req = 2'b00;
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("abort_oe",   32'(uio_oe), 32'h00);
      check("abort_busy", 32'(busy),   32'd0);
      step(4);
      check("abort_no_done", 32'(n_done1), 32'd0);

      // Read burst then write burst: write beat starts right after grant unless TURN built in
      req = 2'b01; dir = 2'b00; len0 = 4'd0;
      step(1);
      req = 2'b00;
      step(2);
      req = 2'b10; dir = 2'b10; len1 = 4'd1; wdata1 = 8'hC8;
      step(1);
      req = 2'b00;
      check("rw_first_cycle_beat", 32'(beat), 32'(TURN_EN ? 2'b00 : 2'b10));
      step(5);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         req    = 2'($urandom_range(0, 3));
         dir    = 2'($urandom_range(0, 3));
         len0   = 4'($urandom_range(0, 3));
         len1   = 4'($urandom_range(0, 3));
         wdata0 = 8'($urandom);
         wdata1 = 8'($urandom);
         uio_in = 8'($urandom);
         ena    = ($urandom_range(0, 9) != 0);
         rst    = ($urandom_range(0, 49) == 0);
         step(1);
      end
      rst = 1'b0; ena = 1'b1; req = 2'b00;
      step(20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
